mb_scheduler_luma16x16: RTL and testbench
=========================================

Name: mb_scheduler_luma16x16

Overview:
- Sequences the luma 16x16 macroblock extractor across one frame in raster order.
- Drives the extractor's enable and mbnumber inputs and holds each macroblock index stable until the extractor's outputs have settled.
- Presents a valid/ready handshake, plus neighbour-availability flags, to the downstream intra-prediction stage.
- Sits between frame-level control (start / frame_done) and the extractor/predictor pair.

Parameters:
- LENGTH, 1280, frame width in pixels.
- WIDTH, 720, frame height in pixels.
- MB_SIZE_L, 16, macroblock width in pixels.
- MB_SIZE_W, 16, macroblock height in pixels.
- EXTRACT_LATENCY, 2, number of consecutive enable cycles the extractor needs before mb/toppixels/leftpixels are valid (legal range 1..15).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request to process one full frame; sampled only in IDLE.
- mb_ready  input  1  downstream accepts the current macroblock.
- extract_enable  output  1  enable to the extractor.
- mbnumber  output  13  raster macroblock index to the extractor.
- mb_row  output  8  macroblock row of mbnumber.
- mb_col  output  8  macroblock column of mbnumber.
- top_avail  output  1  high when mb_row != 0.
- left_avail  output  1  high when mb_col != 0.
- mb_valid  output  1  extractor outputs are valid for mbnumber.
- busy  output  1  high in any state except IDLE.
- frame_done  output  1  one-cycle pulse after the last macroblock is accepted.

Behaviour:
- Derived constants:
  - MBS_PER_ROW = LENGTH/MB_SIZE_L (80).
  - MB_ROWS = WIDTH/MB_SIZE_W (45).
  - TOTAL = MBS_PER_ROW*MB_ROWS (3600); must be at most 8192.
- Reset (reset==0 at clk edge):
  - State goes to IDLE.
  - All outputs are 0: extract_enable, mbnumber, mb_row, mb_col, top_avail, left_avail, mb_valid, busy, frame_done.
  - Internal latency counter is 0.
  - Reset applies from any state, including mid-frame; no partial-frame resume.
- FSM states: IDLE, ISSUE, HOLD, DONE.
- IDLE:
  - start==1 -> ISSUE; mbnumber, mb_row and mb_col load 0; latency counter loads 0.
  - start==0 -> remain in IDLE.
- ISSUE:
  - extract_enable=1; the latency counter increments each cycle.
  - When the counter reaches EXTRACT_LATENCY-1 -> HOLD.
  - mbnumber, mb_row and mb_col are stable throughout ISSUE.
- HOLD:
  - extract_enable=0, mb_valid=1.
  - mbnumber and the extractor outputs stay frozen (the extractor is not enabled).
  - On mb_ready==1 in this state (handshake):
    - If mbnumber==TOTAL-1 -> DONE.
    - Otherwise advance to the next macroblock and go to ISSUE with counter=0.
  - Advancing the macroblock:
    - mb_col+1 while mb_col < MBS_PER_ROW-1.
    - Otherwise mb_col=0 and mb_row+1.
    - mbnumber+1 (incremental; no multiplier).
  - mb_ready==0 -> remain in HOLD indefinitely. Backpressure has no timeout.
- DONE:
  - frame_done=1 for exactly one cycle, busy=1.
  - Next state is IDLE unconditionally.
- mb_valid is 1 only in HOLD and drops in the cycle after the handshake.
- mb_valid is never asserted while extract_enable=1.
- top_avail and left_avail are combinational from mb_row/mb_col. Both are 0 after reset.
- busy=1 in ISSUE, HOLD and DONE.
- start is ignored outside IDLE, including in the DONE cycle.
- mb_ready outside HOLD is ignored.
- Timing, with start sampled at edge t:
  - extract_enable is high for cycles t+1 .. t+EXTRACT_LATENCY.
  - mb_valid rises at t+EXTRACT_LATENCY+1.
  - Minimum per-macroblock period is EXTRACT_LATENCY+1 cycles with mb_ready tied high.
  - A full frame with mb_ready=1 takes TOTAL*(EXTRACT_LATENCY+1)+1 cycles from start to the frame_done pulse, inclusive.
- Arithmetic:
  - mbnumber never exceeds TOTAL-1.
  - mb_row never exceeds MB_ROWS-1.
  - mb_col never exceeds MBS_PER_ROW-1.
  - No wrap past the end of the frame; DONE is entered instead.

Test Plan:
1. Reset check: hold reset=0 for 3 cycles with start=1 and mb_ready=1 -> all outputs 0 and state IDLE; then release with start=0 -> outputs stay 0.
2. Small frame, ready always high: LENGTH=64, WIDTH=32, EXTRACT_LATENCY=2, start pulse then mb_ready=1.
   - mbnumber sequence is 0..7, each with enable high for 2 cycles then mb_valid for 1 cycle.
   - Row wrap at mbnumber 4: mb_row=1, mb_col=0, left_avail=0, top_avail=1.
   - frame_done pulses once, 25 cycles after start; busy returns to 0 the following cycle.
3. Backpressure: same config, hold mb_ready=0 for 10 cycles at mbnumber 2 -> mb_valid stays 1, mbnumber stays 2, extract_enable stays 0; on mb_ready=1, mbnumber advances to 3 next cycle.
4. start while busy: pulse start at mbnumber 5 and again in the frame_done cycle -> no restart; exactly 8 macroblocks are issued and one frame_done pulse occurs.
5. Reset mid-frame: assert reset=0 in HOLD at mbnumber 6 -> next cycle all outputs 0; a new start restarts from mbnumber 0.
6. Default parameters: run a full frame with random mb_ready.
   - 3600 handshakes occur; the last has mbnumber=3599, mb_row=44, mb_col=79.
   - mb_valid and extract_enable are never high together.

Source files
------------

// File: rtl/mb_scheduler_luma16x16_if.sv
// Control/handshake bundle between the macroblock scheduler, frame control,
// the luma extractor and the intra-prediction stage.
interface mb_scheduler_luma16x16_if;
  logic        start;
  logic        mb_ready;
  logic        extract_enable;
  logic [12:0] mbnumber;
  logic [7:0]  mb_row;
  logic [7:0]  mb_col;
  logic        top_avail;
  logic        left_avail;
  logic        mb_valid;
  logic        busy;
  logic        frame_done;

  modport master (
    input  start, mb_ready,
    output extract_enable, mbnumber, mb_row, mb_col,
           top_avail, left_avail, mb_valid, busy, frame_done
  );

  modport slave (
    output start, mb_ready,
    input  extract_enable, mbnumber, mb_row, mb_col,
           top_avail, left_avail, mb_valid, busy, frame_done
  );
endinterface

// File: rtl/mb_scheduler_luma16x16.sv
// Raster-order macroblock sequencer: enables the luma extractor for a fixed
// latency per macroblock, then holds the result under a valid/ready handshake.
module mb_scheduler_luma16x16 #(
  parameter int LENGTH          = 1280,
  parameter int WIDTH           = 720,
  parameter int MB_SIZE_L       = 16,
  parameter int MB_SIZE_W       = 16,
  parameter int EXTRACT_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  mb_scheduler_luma16x16_if.master    bus
);
  localparam int MBS_PER_ROW = LENGTH / MB_SIZE_L;
  localparam int MB_ROWS     = WIDTH / MB_SIZE_W;
  localparam int TOTAL       = MBS_PER_ROW * MB_ROWS;

  localparam logic [12:0] LAST_MB  = 13'(TOTAL - 1);
  localparam logic [7:0]  LAST_COL = 8'(MBS_PER_ROW - 1);
  localparam logic [3:0]  LAT_LAST = 4'(EXTRACT_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, HOLD, DONE} state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        en_q, valid_q, busy_q, done_q;
  logic [12:0] mbn_q, mbn_d;
  logic [7:0]  row_q, row_d;
  logic [7:0]  col_q, col_d;

  // Next raster position, computed incrementally so no multiplier is needed.
  always_comb begin
    mbn_d = mbn_q + 13'd1;
    row_d = row_q;
    col_d = col_q + 8'd1;
    if (col_q == LAST_COL) begin
      col_d = 8'd0;
      row_d = row_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      en_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mbn_q   <= 13'd0;
      row_q   <= 8'd0;
      col_q   <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= ISSUE;
            cnt_q   <= 4'd0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            mbn_q   <= 13'd0;
            row_q   <= 8'd0;
            col_q   <= 8'd0;
          end
        end
        ISSUE: begin
          if (cnt_q == LAT_LAST) begin
            state_q <= HOLD;
            en_q    <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        HOLD: begin
          if (bus.mb_ready) begin
            valid_q <= 1'b0;
            if (mbn_q == LAST_MB) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ISSUE;
              cnt_q   <= 4'd0;
              en_q    <= 1'b1;
              mbn_q   <= mbn_d;
              row_q   <= row_d;
              col_q   <= col_d;
            end
          end
        end
        DONE: begin
          // start is deliberately not sampled here; a new frame needs IDLE.
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.extract_enable = en_q;
  assign bus.mbnumber       = mbn_q;
  assign bus.mb_row         = row_q;
  assign bus.mb_col         = col_q;
  assign bus.top_avail      = (row_q != 8'd0);
  assign bus.left_avail     = (col_q != 8'd0);
  assign bus.mb_valid       = valid_q;
  assign bus.busy           = busy_q;
  assign bus.frame_done     = done_q;
endmodule

// File: tb/tb_mb_scheduler_luma16x16.sv
// Bench for the macroblock scheduler: a 4x2 macroblock frame for sequencing,
// backpressure and reset cases, plus the default 80x45 frame with random ready.
module tb_mb_scheduler_luma16x16;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s, rst_f;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   chk_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  mb_scheduler_luma16x16_if s_if();
  mb_scheduler_luma16x16_if f_if();

  mb_scheduler_luma16x16 #(
    .LENGTH(64), .WIDTH(32), .MB_SIZE_L(16), .MB_SIZE_W(16), .EXTRACT_LATENCY(2)
  ) u_small (.clk(clk), .reset(rst_s), .bus(s_if));

  mb_scheduler_luma16x16 u_full (.clk(clk), .reset(rst_f), .bus(f_if));

  typedef struct packed {
    logic [12:0] mbn;
    logic [7:0]  row;
    logic [7:0]  col;
  } mb_t;

  mb_t sb[$];

  function automatic void push_frame(input int nrow, input int ncol);
    mb_t e;
    sb.delete();
    for (int r = 0; r < nrow; r++)
      for (int c = 0; c < ncol; c++) begin
        e.mbn = 13'(r * ncol + c);
        e.row = 8'(r);
        e.col = 8'(c);
        sb.push_back(e);
      end
  endfunction

  function automatic logic [34:0] outs_s();
    return {s_if.extract_enable, s_if.mbnumber, s_if.mb_row, s_if.mb_col,
            s_if.top_avail, s_if.left_avail, s_if.mb_valid, s_if.busy, s_if.frame_done};
  endfunction

  function automatic logic [34:0] outs_f();
    return {f_if.extract_enable, f_if.mbnumber, f_if.mb_row, f_if.mb_col,
            f_if.top_avail, f_if.left_avail, f_if.mb_valid, f_if.busy, f_if.frame_done};
  endfunction

  task automatic test_reset();
    rst_s = 1'b0; rst_f = 1'b0;
    s_if.start = 1'b1; s_if.mb_ready = 1'b1;
    f_if.start = 1'b1; f_if.mb_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (outs_s() !== 35'd0) $display("FAIL reset_small outs=%h want 0", outs_s());
    else pass_cnt++;
    chk_cnt++;
    if (outs_f() !== 35'd0) $display("FAIL reset_full outs=%h want 0", outs_f());
    else pass_cnt++;
    s_if.start = 1'b0; f_if.start = 1'b0;
    rst_s = 1'b1; rst_f = 1'b1;
    repeat (2) @(negedge clk);
    chk_cnt++;
    if (outs_s() !== 35'd0) $display("FAIL post_reset_small outs=%h want 0", outs_s());
    else pass_cnt++;
    chk_cnt++;
    if (outs_f() !== 35'd0) $display("FAIL post_reset_full outs=%h want 0", outs_f());
    else pass_cnt++;
  endtask

  // One small frame; optional stall at macroblock bp_at and optional start spam.
  task automatic run_small(input int bp_at, input int bp_len, input bit spam,
                           output int hs, output int dones, output int dur);
    int c0, stall, en_run;
    bit finished, spam_done, prev_hs_bp, seen_done;
    mb_t e;
    logic [30:0] got, exp;
    stall = 0; en_run = 0;
    finished = 0; spam_done = 0; prev_hs_bp = 0; seen_done = 0;
    hs = 0; dones = 0; dur = -1;
    push_frame(2, 4);
    @(negedge clk);
    s_if.start = 1'b1; s_if.mb_ready = 1'b1; c0 = cyc;
    for (int k = 0; k < 300 && !finished; k++) begin
      @(negedge clk);
      s_if.start = 1'b0;
      if (seen_done) begin
        chk_cnt++;
        if (s_if.busy !== 1'b0 || s_if.extract_enable !== 1'b0)
          $display("FAIL idle_after_done busy=%b en=%b want 0 0", s_if.busy, s_if.extract_enable);
        else pass_cnt++;
        finished = 1;
      end
      if (prev_hs_bp) begin
        chk_cnt++;
        if (s_if.mbnumber !== 13'(bp_at + 1))
          $display("FAIL bp_advance mbnumber=%0d want %0d", s_if.mbnumber, bp_at + 1);
        else pass_cnt++;
        prev_hs_bp = 0;
      end
      chk_cnt++;
      if (s_if.extract_enable && s_if.mb_valid)
        $display("FAIL en_valid_overlap en=1 valid=1 want not both");
      else pass_cnt++;
      if (s_if.extract_enable) en_run++;
      if (s_if.mb_valid && en_run != 0) begin
        chk_cnt++;
        if (en_run != 2) $display("FAIL enable_len got %0d want 2", en_run);
        else pass_cnt++;
        en_run = 0;
      end
      s_if.mb_ready = 1'b1;
      if (bp_len > 0 && stall == 0 && s_if.mb_valid && s_if.mbnumber == 13'(bp_at)) begin
        s_if.mb_ready = 1'b0;
        stall = 1;
      end else if (stall >= 1 && stall <= bp_len) begin
        chk_cnt++;
        if (s_if.mb_valid !== 1'b1 || s_if.mbnumber !== 13'(bp_at) || s_if.extract_enable !== 1'b0)
          $display("FAIL bp_hold valid=%b mbn=%0d en=%b want 1 %0d 0",
                   s_if.mb_valid, s_if.mbnumber, s_if.extract_enable, bp_at);
        else pass_cnt++;
        if (stall < bp_len) s_if.mb_ready = 1'b0;
        else prev_hs_bp = 1;
        stall++;
      end
      if (s_if.mb_valid && s_if.mb_ready) begin
        hs++;
        got = {s_if.mbnumber, s_if.mb_row, s_if.mb_col, s_if.top_avail, s_if.left_avail};
        chk_cnt++;
        if (sb.size() == 0) $display("FAIL sb_small unexpected handshake mbn=%0d", s_if.mbnumber);
        else begin
          e = sb.pop_front();
          exp = {e.mbn, e.row, e.col, e.row != 8'd0, e.col != 8'd0};
          if (got !== exp) $display("FAIL sb_small got=%h want=%h", got, exp);
          else pass_cnt++;
        end
      end
      if (spam && !spam_done && s_if.extract_enable && s_if.mbnumber == 13'd5) begin
        s_if.start = 1'b1;
        spam_done = 1;
      end
      if (s_if.frame_done) begin
        dones++;
        if (!seen_done) dur = cyc - c0;
        seen_done = 1;
        if (spam) s_if.start = 1'b1;
      end
    end
    s_if.start = 1'b0;
    chk_cnt++;
    if (!finished) $display("FAIL small_timeout frame_done not seen within budget");
    else pass_cnt++;
    chk_cnt++;
    if (sb.size() != 0) $display("FAIL sb_small_left got %0d pending want 0", sb.size());
    else pass_cnt++;
  endtask

  task automatic test_small_frame();
    int hs, dn, dur;
    run_small(-1, 0, 1'b0, hs, dn, dur);
    chk_cnt++;
    if (hs != 8 || dn != 1) $display("FAIL small_counts hs=%0d done=%0d want 8 1", hs, dn);
    else pass_cnt++;
    chk_cnt++;
    if (dur != 25) $display("FAIL small_duration got %0d want 25", dur);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int hs, dn, dur;
    run_small(2, 10, 1'b0, hs, dn, dur);
    chk_cnt++;
    if (hs != 8 || dur != 35) $display("FAIL bp_counts hs=%0d dur=%0d want 8 35", hs, dur);
    else pass_cnt++;
  endtask

  task automatic test_start_busy();
    int hs, dn, dur;
    run_small(-1, 0, 1'b1, hs, dn, dur);
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (hs != 8 || dn != 1 || s_if.busy !== 1'b0)
      $display("FAIL start_busy hs=%0d done=%0d busy=%b want 8 1 0", hs, dn, s_if.busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    bit hit;
    int hs, dn, dur;
    hit = 0;
    @(negedge clk);
    s_if.start = 1'b1; s_if.mb_ready = 1'b1;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      s_if.start = 1'b0;
      if (s_if.mb_valid && s_if.mbnumber == 13'd6) begin
        rst_s = 1'b0;
        hit = 1;
      end
    end
    chk_cnt++;
    if (!hit) $display("FAIL reset_mid_timeout hold at mbnumber 6 not reached");
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (outs_s() !== 35'd0) $display("FAIL reset_mid outs=%h want 0", outs_s());
    else pass_cnt++;
    rst_s = 1'b1;
    run_small(-1, 0, 1'b0, hs, dn, dur);
    chk_cnt++;
    if (hs != 8 || dn != 1) $display("FAIL restart_counts hs=%0d done=%0d want 8 1", hs, dn);
    else pass_cnt++;
  endtask

  task automatic test_full_random();
    int hs, ovl, dn;
    bit fin;
    mb_t e;
    logic [30:0] got, exp;
    logic [12:0] lm;
    logic [7:0] lr, lc;
    hs = 0; ovl = 0; dn = 0; fin = 0;
    lm = '0; lr = '0; lc = '0;
    push_frame(45, 80);
    @(negedge clk);
    f_if.start = 1'b1; f_if.mb_ready = 1'b0;
    for (int k = 0; k < 40000 && !fin; k++) begin
      @(negedge clk);
      f_if.start = 1'b0;
      if (f_if.extract_enable && f_if.mb_valid) ovl++;
      f_if.mb_ready = 1'($urandom_range(0, 1));
      if (f_if.mb_valid && f_if.mb_ready) begin
        hs++;
        lm = f_if.mbnumber; lr = f_if.mb_row; lc = f_if.mb_col;
        got = {f_if.mbnumber, f_if.mb_row, f_if.mb_col, f_if.top_avail, f_if.left_avail};
        chk_cnt++;
        if (sb.size() == 0) $display("FAIL sb_full unexpected handshake mbn=%0d", f_if.mbnumber);
        else begin
          e = sb.pop_front();
          exp = {e.mbn, e.row, e.col, e.row != 8'd0, e.col != 8'd0};
          if (got !== exp) $display("FAIL sb_full got=%h want=%h", got, exp);
          else pass_cnt++;
        end
      end
      if (f_if.frame_done) begin
        dn++;
        fin = 1;
      end
    end
    f_if.mb_ready = 1'b0;
    chk_cnt++;
    if (!fin) $display("FAIL full_timeout frame_done not seen within budget");
    else pass_cnt++;
    chk_cnt++;
    if (hs != 3600 || dn != 1) $display("FAIL full_counts hs=%0d done=%0d want 3600 1", hs, dn);
    else pass_cnt++;
    chk_cnt++;
    if (lm !== 13'd3599 || lr !== 8'd44 || lc !== 8'd79)
      $display("FAIL full_last mbn=%0d row=%0d col=%0d want 3599 44 79", lm, lr, lc);
    else pass_cnt++;
    chk_cnt++;
    if (ovl != 0) $display("FAIL full_overlap got %0d cycles want 0", ovl);
    else pass_cnt++;
  endtask

  initial begin
    rst_s = 1'b0; rst_f = 1'b0;
    s_if.start = 1'b0; s_if.mb_ready = 1'b0;
    f_if.start = 1'b0; f_if.mb_ready = 1'b0;
    test_reset();
    test_small_frame();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    test_full_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
